// File: rtl/arbiter_pkg.sv
// Shared types for the round-robin arbiter slice.
package arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage : arbiter_pkg

// File: rtl/priority_encoder_tree.sv
// Lowest-set-bit priority encoder. The input is split into groups of SPLIT
// bits; IMPLEMENTATION picks one of several functionally identical encoders.
module priority_encoder_tree #(
  parameter  int unsigned WIDTH          = 16,
  parameter  int unsigned SPLIT          = 4,
  parameter  int unsigned IMPLEMENTATION = 0,
  localparam int unsigned IW             = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [IW-1:0]    idx_o,
  output logic             vld_o
);

  localparam int unsigned NG = (WIDTH + SPLIT - 1) / SPLIT;

  logic [NG-1:0] grp_any;

  // Per-group OR reduction; also yields the overall valid flag
  always_comb begin
    grp_any = '0;
    for (int unsigned g = 0; g < NG; g++) begin
      for (int unsigned k = 0; k < SPLIT; k++) begin
        if (g * SPLIT + k < WIDTH) grp_any[g] = grp_any[g] | in_i[g*SPLIT+k];
      end
    end
  end

  assign vld_o = |grp_any;

  if (IMPLEMENTATION == 0) begin : g_scan_down
    // Scan from the top so the last hit is the lowest index
    always_comb begin
      idx_o = '0;
      for (int unsigned i = WIDTH; i > 0; i--) begin
        if (in_i[i-1]) idx_o = IW'(i - 1);
      end
    end
  end else if (IMPLEMENTATION == 1) begin : g_two_level
    int unsigned sel;
    // Pick the lowest non-empty group, then the lowest bit inside it
    always_comb begin
      sel = 0;
      for (int unsigned g = NG; g > 0; g--) begin
        if (grp_any[g-1]) sel = g - 1;
      end
      idx_o = '0;
      for (int unsigned k = SPLIT; k > 0; k--) begin
        if ((sel * SPLIT + k - 1 < WIDTH) && in_i[sel*SPLIT+k-1])
          idx_o = IW'(sel * SPLIT + k - 1);
      end
    end
  end else if (IMPLEMENTATION == 2) begin : g_isolate
    logic [WIDTH-1:0] lsb;
    // Isolate the lowest set bit, then OR-encode the one-hot result
    always_comb begin
      lsb   = in_i & (~in_i + WIDTH'(1));
      idx_o = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (lsb[i]) idx_o = idx_o | IW'(i);
      end
    end
  end else begin : g_scan_up
    logic found;
    // Ascending scan that locks on the first hit (IMPLEMENTATION 3 and up)
    always_comb begin
      idx_o = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (!found && in_i[i]) begin
          idx_o = IW'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule : priority_encoder_tree

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered one-hot grant and optional preemption
// of an owner that has held the grant for HOLD cycles.
module round_robin_arbiter
  import arbiter_pkg::*;
#(
  parameter  int unsigned WIDTH          = 16,
  parameter  int unsigned SPLIT          = 4,
  parameter  int unsigned IMPLEMENTATION = 0,
  parameter  int unsigned HOLD           = 4,
  localparam int unsigned IW             = $clog2(WIDTH),
  localparam int unsigned CW             = (HOLD > 0) ? $clog2(HOLD + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             gnt_vld
);

  localparam logic [CW-1:0] CNT_MAX = (HOLD == 0) ? CW'(1) : CW'(HOLD);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] gnt_q, gnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] req_eff, mask;
  logic [IW-1:0]    m_idx, u_idx, winner;
  logic             m_vld, any_req, grant_new;

  // Current owner is excluded from arbitration while it holds the grant
  always_comb begin
    req_eff = (state_q == GRANT) ? (req & ~gnt_q) : req;
    mask    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) mask[i] = (IW'(i) > ptr_q);
  end

  priority_encoder_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_enc_masked (
    .in_i  (req_eff & mask),
    .idx_o (m_idx),
    .vld_o (m_vld)
  );

  priority_encoder_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_enc_unmasked (
    .in_i  (req_eff),
    .idx_o (u_idx),
    .vld_o (any_req)
  );

  assign winner = m_vld ? m_idx : u_idx;

  // Next-state: new grant, release to idle, preemption, or hold with count
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    grant_new = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) grant_new = 1'b1;
      end
      GRANT: begin
        if (!req[ptr_q]) begin
          if (any_req) begin
            grant_new = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else if ((HOLD != 0) && (cnt_q == CNT_MAX) && any_req) begin
          grant_new = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_new) begin
      state_d = GRANT;
      ptr_d   = winner;
      gnt_d   = WIDTH'(1) << winner;
      cnt_d   = CW'(1);
    end
  end

  // State registers; reset points ptr at the top so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(WIDTH - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = ptr_q;
  assign gnt_vld = (state_q == GRANT);

endmodule : round_robin_arbiter

// File: tb/tb_round_robin_arbiter.sv
// Directed bench: one arbiter per encoder implementation, all driven by the
// same request vector and checked against hand-computed grant sequences.
module tb_round_robin_arbiter;

  localparam int NI = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] gnt [NI];
  logic [3:0]  idx [NI];
  logic        vld [NI];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    round_robin_arbiter #(
      .WIDTH          (16),
      .SPLIT          (4),
      .IMPLEMENTATION (g),
      .HOLD           (4)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt[g]),
      .gnt_idx (idx[g]),
      .gnt_vld (vld[g])
    );
  end

  task automatic chk(input string tag, input int inst,
                     input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s impl=%0d observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input int ei);
    logic [31:0] eg;
    eg = ev ? (32'd1 << ei) : 32'd0;
    for (int g = 0; g < NI; g++) begin
      chk({tag, "_vld"}, g, 32'(vld[g]), 32'(ev));
      chk({tag, "_idx"}, g, 32'(idx[g]), 32'(ei));
      chk({tag, "_gnt"}, g, 32'(gnt[g]), eg);
      chk({tag, "_cons"}, g, 32'(gnt[g]), vld[g] ? (32'd1 << idx[g]) : 32'd0);
    end
  endtask

  task automatic step(input string tag, input logic ev, input int ei);
    @(posedge clk);
    #1;
    check_all(tag, ev, ei);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, asynchronous assertion before any clock edge
    #1;
    rst_n = 1'b0;
    #1;
    check_all("rst_async", 1'b0, 15);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // No requests: stay idle
    for (int c = 0; c < 5; c++) step("idle", 1'b0, 15);

    // Rotation: each owner drops one cycle after grant, no idle bubble
    req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      step("rotate", 1'b1, k % 16);
      req = 16'hFFFF & ~(16'd1 << (k % 16));
    end
    req = 16'h0000;
    step("rotate_idle", 1'b0, 0);

    // Preemption after HOLD cycles between requesters 0 and 7
    do_reset();
    req = 16'h0081;
    for (int c = 0; c < 4; c++) step("preempt_a", 1'b1, 0);
    for (int c = 0; c < 4; c++) step("preempt_b", 1'b1, 7);
    for (int c = 0; c < 4; c++) step("preempt_c", 1'b1, 0);
    req = 16'h0000;
    step("preempt_idle", 1'b0, 0);

    // Lone requester keeps the grant indefinitely
    req = 16'h0020;
    for (int c = 0; c < 20; c++) step("solo", 1'b1, 5);
    req = 16'h0000;
    step("solo_drop", 1'b0, 5);

    // Mid-grant asynchronous reset, then wrap from ptr=15
    req = 16'h0200;
    step("pre_rst_a", 1'b1, 9);
    step("pre_rst_b", 1'b1, 9);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("rst_mid", 1'b0, 15);
    @(negedge clk);
    rst_n = 1'b1;
    req = 16'h0600;
    step("post_rst", 1'b1, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_round_robin_arbiter
